// File: rtl/seq_divider_if.sv
// Handshake and result bundle for the sequential divider.
// The requester drives start/a/b; the divider returns busy/done and the held result.
interface seq_divider_if #(
   parameter int N = 16
);
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         busy;
   logic         done;
   logic [N-1:0] q;
   logic [N-1:0] r;
   logic         dz;

   modport master (
      output start, a, b,
      input  busy, done, q, r, dz
   );

   modport slave (
      input  start, a, b,
      output busy, done, q, r, dz
   );
endinterface

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Results (q, r, dz) are held from one done pulse to the next.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; operands captured on the accepting edge
//   CALC  | N restoring iterations; results loaded on the last one
//   DONE  | one-cycle done pulse, then back to IDLE unconditionally
module seq_divider #(
   parameter int N = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   seq_divider_if.slave bus
);

   localparam int CW = $clog2(N) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_nx;

   logic          accept;
   logic          step;
   logic          busy;
   logic          done;
   logic          last;

   logic [N-1:0]  dvd;
   logic [N-1:0]  dvs;
   logic [N-1:0]  rem;
   logic [CW-1:0] cnt;
   logic          dz_pend;
   logic [N-1:0]  q_reg;
   logic [N-1:0]  r_reg;
   logic          dz_reg;

   logic [N:0]    shifted;
   logic          fits;
   logic [N-1:0]  rem_nx;
   logic [N-1:0]  dvd_nx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.start) state_nx = CALC;
         CALC:    if (last)      state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      accept = 1'b0;
      step   = 1'b0;
      busy   = 1'b0;
      done   = 1'b0;
      case (state)
         IDLE: accept = bus.start;
         CALC: begin
            step = 1'b1;
            busy = 1'b1;
         end
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   // A restored remainder is always below the divisor (or equal to the
   // shifted-in dividend prefix when dividing by zero), so its top bit is
   // always zero and only N bits are stored; the trial itself is N+1 bits.
   assign shifted = {rem, dvd[N-1]};
   assign fits    = (shifted >= {1'b0, dvs});
   assign rem_nx  = fits ? N'(shifted - {1'b0, dvs}) : shifted[N-1:0];
   assign dvd_nx  = {dvd[N-2:0], fits};
   assign last    = (cnt == CW'(N - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dvd     <= '0;
         dvs     <= '0;
         rem     <= '0;
         cnt     <= '0;
         dz_pend <= 1'b0;
         q_reg   <= '0;
         r_reg   <= '0;
         dz_reg  <= 1'b0;
      end else if (accept) begin
         dvd     <= bus.a;
         dvs     <= bus.b;
         rem     <= '0;
         cnt     <= '0;
         dz_pend <= (bus.b == '0);
      end else if (step) begin
         dvd <= dvd_nx;
         rem <= rem_nx;
         cnt <= cnt + 1'b1;
         if (last) begin
            q_reg  <= dvd_nx;
            r_reg  <= rem_nx;
            dz_reg <= dz_pend;
         end
      end
   end

   assign bus.busy = busy;
   assign bus.done = done;
   assign bus.q    = q_reg;
   assign bus.r    = r_reg;
   assign bus.dz   = dz_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vectors, handshake corner
// cases, mid-operation reset and a randomized run against plain arithmetic.
module tb_seq_divider;

   localparam int N   = 16;
   localparam int LAT = N;

   logic clk;
   logic rst_n;

   seq_divider_if #(.N(N)) bus ();

   seq_divider #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt  = 0;
   int total_cnt = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] q;
      logic [15:0] r;
      logic        dz;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Issue one division; optionally pulse start again poke cycles after acceptance.
   task automatic run_op(input logic [15:0] ta, input logic [15:0] tbv, input int poke,
                         output logic [15:0] gq, output logic [15:0] gr, output logic gdz,
                         output int lat, output bit stable, output logic busy_at_done);
      logic [15:0] q0;
      logic [15:0] r0;
      logic        dz0;
      q0 = bus.q;
      r0 = bus.r;
      dz0 = bus.dz;
      stable = 1'b1;
      bus.start = 1'b1;
      bus.a = ta;
      bus.b = tbv;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
      lat = 0;
      while (!bus.done && lat < 40) begin
         if (bus.q !== q0 || bus.r !== r0 || bus.dz !== dz0) stable = 1'b0;
         if (lat == poke) begin
            bus.start = 1'b1;
            bus.a = 16'd7;
            bus.b = 16'd2;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      bus.start = 1'b0;
      gq = bus.q;
      gr = bus.r;
      gdz = bus.dz;
      busy_at_done = bus.busy;
      @(posedge clk); #1;
      check("done_one_cycle", {31'd0, bus.done}, 32'd0);
      check("busy_falls", {31'd0, bus.busy}, 32'd0);
   endtask

   task automatic check_result(input string tag, input logic [15:0] ta, input logic [15:0] tbv,
                               input logic [15:0] gq, input logic [15:0] gr, input logic gdz,
                               input int lat, input bit stable, input logic bad);
      logic [15:0] eq;
      logic [15:0] er;
      logic        edz;
      if (tbv == 16'd0) begin
         eq = 16'hFFFF;
         er = ta;
         edz = 1'b1;
      end else begin
         eq = ta / tbv;
         er = ta % tbv;
         edz = 1'b0;
      end
      check({tag, "_q"}, {16'd0, gq}, {16'd0, eq});
      check({tag, "_r"}, {16'd0, gr}, {16'd0, er});
      check({tag, "_dz"}, {31'd0, gdz}, {31'd0, edz});
      check({tag, "_latency"}, lat, LAT);
      check({tag, "_held"}, {31'd0, stable}, 32'd1);
      check({tag, "_busy_at_done"}, {31'd0, bad}, 32'd1);
   endtask

   vec_t vecs[8];

   initial begin
      logic [15:0] gq;
      logic [15:0] gr;
      logic        gdz;
      logic        bad;
      int          lat;
      bit          stable;
      int          pulses[$];
      int          done_seen;

      vecs[0] = '{16'd100,   16'd7,      16'd14,     16'd2, 1'b0};
      vecs[1] = '{16'hFFFF,  16'd1,      16'hFFFF,   16'd0, 1'b0};
      vecs[2] = '{16'hFFFF,  16'hFFFF,   16'd1,      16'd0, 1'b0};
      vecs[3] = '{16'd3,     16'd10,     16'd0,      16'd3, 1'b0};
      vecs[4] = '{16'd5,     16'd0,      16'hFFFF,   16'd5, 1'b1};
      vecs[5] = '{16'd9,     16'd3,      16'd3,      16'd0, 1'b0};
      vecs[6] = '{16'd0,     16'd5,      16'd0,      16'd0, 1'b0};
      vecs[7] = '{16'd50,    16'd6,      16'd8,      16'd2, 1'b0};

      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.a = '0;
      bus.b = '0;
      #2;
      check("reset_busy", {31'd0, bus.busy}, 32'd0);
      check("reset_done", {31'd0, bus.done}, 32'd0);
      check("reset_q", {16'd0, bus.q}, 32'd0);
      check("reset_r", {16'd0, bus.r}, 32'd0);
      check("reset_dz", {31'd0, bus.dz}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].a, vecs[i].b, -1, gq, gr, gdz, lat, stable, bad);
         check($sformatf("vec%0d_q", i), {16'd0, gq}, {16'd0, vecs[i].q});
         check($sformatf("vec%0d_r", i), {16'd0, gr}, {16'd0, vecs[i].r});
         check($sformatf("vec%0d_dz", i), {31'd0, gdz}, {31'd0, vecs[i].dz});
         check($sformatf("vec%0d_latency", i), lat, LAT);
         check($sformatf("vec%0d_held", i), {31'd0, stable}, 32'd1);
      end

      // start pulsed mid-CALC must not disturb the running division
      run_op(16'd1000, 16'd10, 5, gq, gr, gdz, lat, stable, bad);
      check("midcalc_q", {16'd0, gq}, 32'd100);
      check("midcalc_r", {16'd0, gr}, 32'd0);
      check("midcalc_latency", lat, LAT);
      @(posedge clk); #1;
      check("midcalc_no_restart", {31'd0, bus.busy}, 32'd0);

      // start held high: back-to-back results every N+2 cycles
      bus.start = 1'b1;
      bus.a = 16'd200;
      bus.b = 16'd9;
      for (int c = 0; c < 60; c++) begin
         @(posedge clk); #1;
         if (bus.done) begin
            pulses.push_back(c);
            check("held_q", {16'd0, bus.q}, 32'd22);
            check("held_r", {16'd0, bus.r}, 32'd2);
         end
      end
      bus.start = 1'b0;
      check("held_pulse_count", pulses.size(), 3);
      if (pulses.size() >= 3) begin
         check("held_spacing_1", pulses[1] - pulses[0], N + 2);
         check("held_spacing_2", pulses[2] - pulses[1], N + 2);
      end
      repeat (N + 4) @(posedge clk);
      #1;

      // reset at edge k+5 aborts the division
      bus.start = 1'b1;
      bus.a = 16'd1234;
      bus.b = 16'd5;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("pre_reset_busy", {31'd0, bus.busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_busy", {31'd0, bus.busy}, 32'd0);
      check("abort_done", {31'd0, bus.done}, 32'd0);
      check("abort_q", {16'd0, bus.q}, 32'd0);
      check("abort_r", {16'd0, bus.r}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      done_seen = 0;
      for (int c = 0; c < N + 6; c++) begin
         @(posedge clk); #1;
         if (bus.done) done_seen++;
      end
      check("abort_no_done", done_seen, 0);
      run_op(16'd50, 16'd6, -1, gq, gr, gdz, lat, stable, bad);
      check_result("post_reset", 16'd50, 16'd6, gq, gr, gdz, lat, stable, bad);

      for (int i = 0; i < 2000; i++) begin
         logic [15:0] ra;
         logic [15:0] rb;
         ra = 16'($urandom_range(0, 65535));
         if ($urandom_range(0, 3) == 0) rb = 16'($urandom_range(1, 15));
         else rb = 16'($urandom_range(1, 65535));
         run_op(ra, rb, -1, gq, gr, gdz, lat, stable, bad);
         check_result("rand", ra, rb, gq, gr, gdz, lat, stable, bad);
         check("rand_identity", 32'(gq) * 32'(rb) + 32'(gr), {16'd0, ra});
         check("rand_r_lt_b", {31'd0, (gr < rb)}, 32'd1);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
      $fatal(1, "watchdog");
   end

endmodule
